// File: rtl/mem_access_stage.sv
// RV64 memory-access stage: loads/stores against an internal doubleword RAM with a
// fixed LATENCY-cycle access, load alignment/extension, and upstream stall control.
module mem_access_stage #(
    parameter int DEPTH_DW = 512,
    parameter int LATENCY  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] MEM_ALUResult,
    input  logic [63:0] MEM_WriteData,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [2:0]  MEM_Funct3,
    output logic [63:0] MEM_MemData,
    output logic        mem_stall,
    output logic        mem_done,
    output logic        mem_fault
);
    localparam int IW = $clog2(DEPTH_DW);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx_q;
    logic [2:0]    off_q;
    logic [2:0]    f3_q;
    logic          store_q;
    logic [63:0]   wdata_q;
    logic [63:0]   mem_data_q;
    logic          done_q;

    logic [63:0] ram [DEPTH_DW];

    logic          req;
    logic [IW-1:0] idx;
    logic [2:0]    off;
    logic          illegal;
    logic          misalign;
    logic          fault_c;
    logic          accept;
    logic          completing;
    logic          last_wait;
    logic [7:0]    be_base;
    logic [7:0]    be;
    logic [63:0]   wshift;
    logic [63:0]   load_src;
    logic [2:0]    ld_off;
    logic [2:0]    ld_f3;
    logic          ld_is_load;
    logic          unused_addr;

    assign req         = MEM_MemRead | MEM_MemWrite;
    assign idx         = MEM_ALUResult[IW+2:3];
    assign off         = MEM_ALUResult[2:0];
    assign unused_addr = ^MEM_ALUResult[63:IW+3];

    // When both read and write are requested the access is a store.
    assign illegal = MEM_MemWrite ? MEM_Funct3[2] : (MEM_Funct3 == 3'b111);

    always_comb begin
        misalign = 1'b0;
        case (MEM_Funct3[1:0])
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = off[0];
            2'b10:   misalign = |off[1:0];
            default: misalign = |off;
        endcase
    end

    assign fault_c    = req & (illegal | misalign);
    assign accept     = (state == IDLE) & req & ~fault_c;
    assign completing = (state == BUSY) && (cnt == '0);
    // The edge that leads into the completing cycle, where load data gets registered.
    assign last_wait  = (LATENCY == 2) ? accept : ((state == BUSY) && (cnt == CW'(1)));

    assign mem_fault   = rst_n & (state == IDLE) & fault_c;
    assign mem_stall   = rst_n & (accept | ((state == BUSY) && (cnt != '0)));
    assign mem_done    = done_q;
    assign MEM_MemData = mem_data_q;

    function automatic logic [63:0] extend(input logic [63:0] dw, input logic [2:0] lane_off,
                                           input logic [2:0] f3);
        logic [63:0] lane;
        logic [63:0] res;
        lane = dw >> {lane_off, 3'b000};
        case (f3)
            3'b000:  res = {{56{lane[7]}}, lane[7:0]};
            3'b001:  res = {{48{lane[15]}}, lane[15:0]};
            3'b010:  res = {{32{lane[31]}}, lane[31:0]};
            3'b100:  res = {56'd0, lane[7:0]};
            3'b101:  res = {48'd0, lane[15:0]};
            3'b110:  res = {32'd0, lane[31:0]};
            default: res = lane;
        endcase
        return res;
    endfunction

    generate
        if (LATENCY == 2) begin : g_direct
            assign load_src   = ram[idx];
            assign ld_off     = off;
            assign ld_f3      = MEM_Funct3;
            assign ld_is_load = ~MEM_MemWrite;
        end else begin : g_staged
            logic [63:0] rd_q;
            always_ff @(posedge clk) begin
                if (accept) rd_q <= ram[idx];
            end
            assign load_src   = rd_q;
            assign ld_off     = off_q;
            assign ld_f3      = f3_q;
            assign ld_is_load = ~store_q;
        end
    endgenerate

    always_comb begin
        be_base = 8'h00;
        case (f3_q[1:0])
            2'b00:   be_base = 8'h01;
            2'b01:   be_base = 8'h03;
            2'b10:   be_base = 8'h0F;
            default: be_base = 8'hFF;
        endcase
    end

    assign be     = be_base << off_q;
    assign wshift = wdata_q << {off_q, 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx_q      <= '0;
            off_q      <= '0;
            f3_q       <= '0;
            store_q    <= 1'b0;
            wdata_q    <= '0;
            mem_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= last_wait;
            if (last_wait && ld_is_load) mem_data_q <= extend(load_src, ld_off, ld_f3);
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx_q   <= idx;
                        off_q   <= off;
                        f3_q    <= MEM_Funct3;
                        store_q <= MEM_MemWrite;
                        wdata_q <= MEM_WriteData;
                        cnt     <= CW'(LATENCY - 2);
                        state   <= BUSY;
                    end
                end
                default: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else state <= IDLE;
                end
            endcase
        end
    end

    // Reset forces state to IDLE asynchronously, so an aborted store never commits here.
    always_ff @(posedge clk) begin
        if (completing && store_q) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) ram[idx_q][b*8 +: 8] <= wshift[b*8 +: 8];
            end
        end
    end

endmodule
